agtb_sweep_checker: RTL and testbench

- Driving end of the 2-bit "a greater than b" comparator interface.
- Sequences every (a, b) operand pair into a comparator under test and samples its agtb response.
- Checks each response against a golden a > b, counts mismatches and records the first failing pair.
- Used as the on-board self-test engine next to the comparator in the lab top-level.

---
 rtl/agtb_pkg.sv | 14 +
 rtl/agtb_ref.sv | 17 +
 rtl/agtb_sweep_checker.sv | 140 ++++++++++++++
 tb/tb_agtb_sweep_checker.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/agtb_pkg.sv
// Shared definitions for the a>b comparator sweep checker.
package agtb_pkg;

   // Default operand width of the comparator under test.
   localparam int AGTB_WIDTH = 2;

   // Sequencer state encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } agtb_state_e;

endpackage

// File: rtl/agtb_ref.sv
// Golden unsigned a > b model used to judge the comparator under test.
module agtb_ref
   import agtb_pkg::*;
#(
   parameter int WIDTH = AGTB_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             gt_o
);

   // Pure combinational compare; both operands are unsigned.
   always_comb begin
      gt_o = (a_i > b_i);
   end

endmodule

// File: rtl/agtb_sweep_checker.sv
// Self-test engine: walks every (a, b) pair into a comparator, samples its
// agtb response after SETTLE cycles, checks it against a local golden model,
// counts mismatches and records the first failing pair.
module agtb_sweep_checker
   import agtb_pkg::*;
#(
   parameter int WIDTH  = AGTB_WIDTH,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   input  logic             agtb_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [2*WIDTH:0] err_count,
   output logic [WIDTH-1:0] first_fail_a,
   output logic [WIDTH-1:0] first_fail_b
);

   localparam int            IW        = 2 * WIDTH;
   localparam logic [IW-1:0] IDX_LAST  = {IW{1'b1}};
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic [3:0]    SETTLE_LD = 4'(SETTLE - 1);

   // Reset release synchroniser: assertion is immediate, release waits two edges.
   logic rst_meta_q;
   logic rst_sync_q;

   // Two-flop release of the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   agtb_state_e      state_q;
   logic [IW-1:0]    idx_q;
   logic [IW-1:0]    idx_d;
   logic [3:0]       cnt_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [IW:0]      err_q;
   logic [IW:0]      err_d;
   logic [WIDTH-1:0] ffa_q;
   logic [WIDTH-1:0] ffb_q;
   logic             exp_gt;
   logic             sample;
   logic             mismatch;

   // Operands come straight from the registered index, a-major order.
   assign a_out = idx_q[IW-1:WIDTH];
   assign b_out = idx_q[WIDTH-1:0];

   agtb_ref #(.WIDTH(WIDTH)) u_ref (
      .a_i  (a_out),
      .b_i  (b_out),
      .gt_o (exp_gt)
   );

   // A sample edge is the last cycle a vector is held.
   always_comb begin
      sample   = (state_q == ST_RUN) && (cnt_q == 4'd0);
      mismatch = sample && (agtb_in != exp_gt);
      err_d    = err_q + (IW+1)'(mismatch);
      idx_d    = idx_q + IDX_ONE;
   end

   // Sweep sequencer with registered status and result outputs.
   always_ff @(posedge clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         ffa_q   <= '0;
         ffb_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q <= ST_RUN;
                  idx_q   <= '0;
                  cnt_q   <= SETTLE_LD;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  err_q   <= '0;
                  ffa_q   <= '0;
                  ffb_q   <= '0;
               end
            end
            ST_RUN: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  err_q <= err_d;
                  // Only the very first mismatch of the sweep is recorded.
                  if (mismatch && (err_q == '0)) begin
                     ffa_q <= a_out;
                     ffb_q <= b_out;
                  end
                  if (idx_q != IDX_LAST) begin
                     idx_q <= idx_d;
                     cnt_q <= SETTLE_LD;
                  end else begin
                     // Last vector stays on the operand bus after completion.
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (err_d == '0);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign err_count    = err_q;
   assign first_fail_a = ffa_q;
   assign first_fail_b = ffb_q;

endmodule

// File: tb/tb_agtb_sweep_checker.sv
// Directed bench for agtb_sweep_checker: comparator models of known
// behaviour are attached and sweep results compared with hand-computed tables.
module tb_agtb_sweep_checker;
   import agtb_pkg::*;

   localparam int W = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start1 = 1'b0;
   logic start3 = 1'b0;
   int   mode = 0;   // 0 good, 1 stuck0, 2 stuck1, 3 inverted, 4 registered

   logic [W-1:0] a1, b1, ffa1, ffb1, a3, b3, ffa3, ffb3;
   logic         agtb1, agtb3, busy1, busy3, done1, done3, pass1, pass3;
   logic [2*W:0] err1, err3;
   logic         q1 = 1'b0;
   logic         q3 = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   agtb_sweep_checker #(.WIDTH(W), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1),
      .agtb_in(agtb1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .first_fail_a(ffa1), .first_fail_b(ffb1)
   );

   agtb_sweep_checker #(.WIDTH(W), .SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .a_out(a3), .b_out(b3),
      .agtb_in(agtb3), .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err3), .first_fail_a(ffa3), .first_fail_b(ffb3)
   );

   // Comparator models under test, one-cycle registered flavour included.
   always_ff @(posedge clk) begin
      q1 <= (a1 > b1);
      q3 <= (a3 > b3);
   end

   always_comb begin
      case (mode)
         0:       begin agtb1 = (a1 > b1);  agtb3 = (a3 > b3);  end
         1:       begin agtb1 = 1'b0;       agtb3 = 1'b0;       end
         2:       begin agtb1 = 1'b1;       agtb3 = 1'b1;       end
         3:       begin agtb1 = !(a1 > b1); agtb3 = !(a3 > b3); end
         default: begin agtb1 = q1;         agtb3 = q3;         end
      endcase
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Pulse start on the chosen instance and count negedges with busy high.
   task automatic run_sweep(input bit s3, output int cyc);
      @(negedge clk);
      if (s3) start3 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
      cyc = 0;
      while ((s3 ? busy3 : busy1) && cyc < 500) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   typedef struct {
      string name;
      int    mode;
      bit    s3;
      int    err;
      int    ffa;
      int    ffb;
      int    pas;
      int    cyc;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int cyc;
      int n;

      tbl[0] = '{"good_s1",     0, 1'b0,  0, 0, 0, 1, 16};
      tbl[1] = '{"stuck0_s1",   1, 1'b0,  6, 1, 0, 0, 16};
      tbl[2] = '{"stuck1_s1",   2, 1'b0, 10, 0, 0, 0, 16};
      tbl[3] = '{"invert_s1",   3, 1'b0, 16, 0, 0, 0, 16};
      tbl[4] = '{"regmodel_s1", 4, 1'b0,  6, 1, 0, 0, 16};
      tbl[5] = '{"regmodel_s3", 4, 1'b1,  0, 0, 0, 1, 48};
      tbl[6] = '{"good_s3",     0, 1'b1,  0, 0, 0, 1, 48};

      // Reset state.
      #12;
      chk("rst_busy", int'(busy1), 0);
      chk("rst_done", int'(done1), 0);
      chk("rst_pass", int'(pass1), 0);
      chk("rst_err",  int'(err1),  0);
      chk("rst_ab",   int'({a1, b1}), 0);
      chk("rst_ff",   int'({ffa1, ffb1}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Table-driven full sweeps.
      foreach (tbl[i]) begin
         mode = tbl[i].mode;
         run_sweep(tbl[i].s3, cyc);
         chk({tbl[i].name, "_cyc"},  cyc, tbl[i].cyc);
         chk({tbl[i].name, "_done"}, int'(tbl[i].s3 ? done3 : done1), 1);
         chk({tbl[i].name, "_pass"}, int'(tbl[i].s3 ? pass3 : pass1), tbl[i].pas);
         chk({tbl[i].name, "_err"},  int'(tbl[i].s3 ? err3 : err1), tbl[i].err);
         chk({tbl[i].name, "_ffa"},  int'(tbl[i].s3 ? ffa3 : ffa1), tbl[i].ffa);
         chk({tbl[i].name, "_ffb"},  int'(tbl[i].s3 ? ffb3 : ffb1), tbl[i].ffb);
      end

      // DONE holds results and the last vector.
      repeat (5) @(negedge clk);
      chk("hold_done", int'(done3), 1);
      chk("hold_pass", int'(pass3), 1);
      chk("hold_ab",   int'({a3, b3}), 15);

      // start in DONE clears results and begins a new sweep.
      mode = 1;
      run_sweep(1'b0, cyc);
      chk("pre_restart_err", int'(err1), 6);
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("restart_busy", int'(busy1), 1);
      chk("restart_done", int'(done1), 0);
      chk("restart_pass", int'(pass1), 0);
      chk("restart_err",  int'(err1), 0);
      chk("restart_ff",   int'({ffa1, ffb1}), 0);
      n = 0;
      while (busy1 && n < 500) begin n++; @(negedge clk); end
      chk("restart_cyc", n, 16);
      chk("restart_err_end", int'(err1), 6);

      // start during RUN (at idx 5) is ignored.
      mode = 0;
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      cyc = 0;
      while (busy1 && cyc < 500) begin
         start1 = (a1 == 2'd1 && b1 == 2'd1);
         cyc++;
         @(negedge clk);
      end
      start1 = 1'b0;
      chk("midstart_cyc",  cyc, 16);
      chk("midstart_pass", int'(pass1), 1);
      chk("midstart_err",  int'(err1), 0);

      // Reset mid-sweep at idx 7 aborts everything.
      mode = 1;
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!(a1 == 2'd1 && b1 == 2'd3) && n < 100) begin n++; @(negedge clk); end
      chk("reach_idx7", int'(a1 == 2'd1 && b1 == 2'd3), 1);
      chk("pre_abort_err", int'(err1), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy1), 0);
      chk("abort_err",  int'(err1), 0);
      chk("abort_ab",   int'({a1, b1}), 0);
      chk("abort_ff",   int'({ffa1, ffb1}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_busy", int'(busy1), 0);
      chk("post_rst_done", int'(done1), 0);
      mode = 0;
      run_sweep(1'b0, cyc);
      chk("post_rst_cyc",  cyc, 16);
      chk("post_rst_pass", int'(pass1), 1);
      chk("post_rst_err",  int'(err1), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
